// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: the fetch phase encoding,
// the default flush word and the PC step.
package fetch_pkg;

    // SETUP: address stable, Enable low. READ: Enable high, memory output valid.
    typedef enum logic {
        SETUP = 1'b0,
        READ  = 1'b1
    } phase_e;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INCR           = 32'd4;

    // Instructions are word aligned; the two low address bits are always dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch stage: reset, branch load, increment,
// hold, and the instruction-memory address mask.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] target,
    input  logic        incr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] addr
);

    // Wrap inside the memory and keep the address word aligned.
    localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1) & 32'hFFFF_FFFC;

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Next PC: a redirect beats an increment; otherwise hold.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = word_align(target);
        end else if (incr) begin
            pc_d = pc_q + PC_INCR;
        end
    end

    // PC state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= word_align(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + PC_INCR;
    assign addr     = pc_q & ADDR_MASK;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage. Drives the instruction memory with a two-phase
// Enable pulse per fetch (SETUP then READ), captures the returned word into the
// IF/ID register, and handles hazard stalls and branch redirect/flush.
// Optional build macro FETCH_PERF_EN adds fetch and stall performance counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 256,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_le,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] imem_data,
    output logic [31:0] imem_addr,
    output logic        imem_enable,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls,
`endif
    output logic        ifid_valid
);

    phase_e      phase_q;
    phase_e      phase_d;
    logic        capture;
    logic        stall_read;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    logic [31:0] ifid_instr_q;
    logic [31:0] ifid_pc4_q;
    logic        ifid_valid_q;

    fetch_pc_reg #(
        .RESET_PC  (RESET_PC),
        .MEM_BYTES (MEM_BYTES)
    ) u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (branch_taken),
        .target   (branch_target),
        .incr     (capture),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .addr     (imem_addr)
    );

    // Phase sequencing: a branch always restarts in SETUP; a stalled READ holds.
    always_comb begin
        phase_d    = phase_q;
        capture    = 1'b0;
        stall_read = 1'b0;
        unique case (phase_q)
            SETUP: begin
                phase_d = branch_taken ? SETUP : READ;
            end
            READ: begin
                if (branch_taken) begin
                    phase_d = SETUP;
                end else if (pc_le) begin
                    capture = 1'b1;
                    phase_d = SETUP;
                end else begin
                    stall_read = 1'b1;
                end
            end
            default: phase_d = SETUP;
        endcase
    end

    // Phase register; async reset drops Enable immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= SETUP;
        end else begin
            phase_q <= phase_d;
        end
    end

    // IF/ID register: flush on branch, load on a completed READ, else hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
        end else if (branch_taken) begin
            // PC+4 is left as is; the flushed slot is marked invalid.
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else if (capture) begin
            ifid_instr_q <= imem_data;
            ifid_pc4_q   <= pc_plus4;
            ifid_valid_q <= 1'b1;
        end
    end

    assign imem_enable = (phase_q == READ);
    assign ifid_instr  = ifid_instr_q;
    assign ifid_pc4    = ifid_pc4_q;
    assign ifid_valid  = ifid_valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stalls_q;

    // Count captures and stalled READ cycles, wrapping modulo 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_q <= 32'h0;
            perf_stalls_q  <= 32'h0;
        end else begin
            if (capture) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (stall_read) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stalls  = perf_stalls_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized stall/branch traffic against a fetch model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_le;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_data;
    logic [31:0] imem_addr;
    logic        imem_enable;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalls;
`endif

    logic [31:0] mem [64];

    int checks   = 0;
    int failures = 0;

    // Model of the fetch unit: where the PC points, whether a read is in
    // flight, and what IF/ID should hold.
    logic [31:0] m_pc;
    bit          m_reading;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    bit          m_valid;
    logic [31:0] m_fetched;
    logic [31:0] m_stalls;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .MEM_BYTES (256),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_le         (pc_le),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_data     (imem_data),
        .imem_addr     (imem_addr),
        .imem_enable   (imem_enable),
        .ifid_instr    (ifid_instr),
        .ifid_pc4      (ifid_pc4),
`ifdef FETCH_PERF_EN
        .perf_fetched  (perf_fetched),
        .perf_stalls   (perf_stalls),
`endif
        .ifid_valid    (ifid_valid)
    );

    always #5 clk = ~clk;

    // Memory returns junk while Enable is low so a stray capture is visible.
    assign imem_data = imem_enable ? mem[imem_addr[7:2]] : 32'hBAD0_BAD0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_addr();
        return m_pc % 256;
    endfunction

    task automatic m_reset();
        m_pc      = 32'h0;
        m_reading = 1'b0;
        m_instr   = NOP;
        m_pc4     = 32'h0;
        m_valid   = 1'b0;
        m_fetched = 32'h0;
        m_stalls  = 32'h0;
    endtask

    // Apply one clock edge's worth of behaviour to the model.
    task automatic m_step();
        if (branch_taken) begin
            m_pc      = branch_target & ~32'd3;
            m_reading = 1'b0;
            m_instr   = NOP;
            m_valid   = 1'b0;
        end else if (!m_reading) begin
            m_reading = 1'b1;
        end else if (pc_le) begin
            m_instr   = mem[m_addr() / 4];
            m_pc4     = m_pc + 32'd4;
            m_valid   = 1'b1;
            m_pc      = m_pc + 32'd4;
            m_reading = 1'b0;
            m_fetched = m_fetched + 32'd1;
        end else begin
            m_stalls = m_stalls + 32'd1;
        end
    endtask

    task automatic compare();
        chk("imem_addr", imem_addr, m_addr());
        chk("imem_enable", {31'b0, imem_enable}, {31'b0, m_reading});
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_pc4", ifid_pc4, m_pc4);
        chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_stalls", perf_stalls, m_stalls);
`endif
    endtask

    // Compare mid-cycle, take the edge, advance the model, settle past the edge.
    task automatic cycle(input logic le, input logic br, input logic [31:0] tgt);
        pc_le         = le;
        branch_taken  = br;
        branch_target = tgt;
        @(negedge clk);
        compare();
        @(posedge clk);
        m_step();
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0]  = 32'h1111_1111;
        mem[1]  = 32'h2222_2222;
        mem[2]  = 32'h3333_3333;
        mem[63] = 32'hFCFC_FCFC;

        reset = 1'b1; pc_le = 1'b1; branch_taken = 1'b0; branch_target = 32'h0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state and first fetches.
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_enable", {31'b0, imem_enable}, 32'h0);
        chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
        chk("rst_instr", ifid_instr, NOP);
        cycle(1, 0, 0);
        chk("read0_enable", {31'b0, imem_enable}, 32'h1);
        chk("read0_addr", imem_addr, 32'h0);
        cycle(1, 0, 0);
        chk("cap0_instr", ifid_instr, 32'h1111_1111);
        chk("cap0_pc4", ifid_pc4, 32'h4);
        chk("cap0_valid", {31'b0, ifid_valid}, 32'h1);
        chk("setup4_addr", imem_addr, 32'h4);
        chk("setup4_enable", {31'b0, imem_enable}, 32'h0);
        cycle(1, 0, 0);

        // Stall three cycles in the READ at address 4.
        repeat (3) cycle(0, 0, 0);
        chk("stall_enable", {31'b0, imem_enable}, 32'h1);
        chk("stall_addr", imem_addr, 32'h4);
        chk("stall_instr", ifid_instr, 32'h1111_1111);
        cycle(1, 0, 0);
        chk("cap1_instr", ifid_instr, 32'h2222_2222);
        chk("cap1_pc4", ifid_pc4, 32'h8);
        cycle(1, 0, 0);

        // Branch during READ at address 8 discards that fetch.
        cycle(1, 1, 32'h42);
        chk("br_valid", {31'b0, ifid_valid}, 32'h0);
        chk("br_instr", ifid_instr, NOP);
        chk("br_pc4", ifid_pc4, 32'h8);
        chk("br_addr", imem_addr, 32'h40);
        chk("br_enable", {31'b0, imem_enable}, 32'h0);
        cycle(1, 0, 0);

        // Branch beats a simultaneous stall.
        cycle(0, 1, 32'h10);
        chk("brstall_addr", imem_addr, 32'h10);
        chk("brstall_enable", {31'b0, imem_enable}, 32'h0);

        // Wrap at the top of memory.
        cycle(1, 1, 32'hFC);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        chk("wrap_instr", ifid_instr, 32'hFCFC_FCFC);
        chk("wrap_pc4", ifid_pc4, 32'h100);
        chk("wrap_addr", imem_addr, 32'h0);

        // Reset asserted in the middle of a READ at 0x10.
        cycle(1, 1, 32'h10);
        cycle(1, 0, 0);
        chk("pre_rst_enable", {31'b0, imem_enable}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_enable", {31'b0, imem_enable}, 32'h0);
        chk("midrst_valid", {31'b0, ifid_valid}, 32'h0);
`ifdef FETCH_PERF_EN
        chk("midrst_fetched", perf_fetched, 32'h0);
        chk("midrst_stalls", perf_stalls, 32'h0);
`endif
        m_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        chk("post_rst_addr", imem_addr, 32'h0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        chk("post_rst_instr", ifid_instr, 32'h1111_1111);

        // Randomized stall and branch traffic.
        for (int n = 0; n < 3000; n++) begin
            logic        le;
            logic        br;
            logic [31:0] tgt;
            le  = ($urandom_range(3) != 0);
            br  = ($urandom_range(9) == 0);
            tgt = ($urandom_range(7) == 0) ? (32'hFFFF_FF00 | $urandom_range(255)) : $urandom;
            cycle(le, br, tgt);
        end
        @(negedge clk);
        compare();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
